// File: rtl/logic_stage.sv
// Registered AND/OR/XOR/NOR stage with a valid/ready handshake and a two-entry
// skid buffer, so in_ready comes straight from a register.
module logic_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    // State encoding is {main_valid, skid_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t       state_reg;
    state_t       state_next;
    logic [N-1:0] main_result_reg;
    logic         main_zero_reg;
    logic [N-1:0] skid_result_reg;
    logic         skid_zero_reg;

    logic [N-1:0] calc;
    logic         calc_zero;
    logic         accept;
    logic         emit;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;

    always_comb begin
        calc = '0;
        case (op)
            2'b00: calc = a & b;
            2'b01: calc = a | b;
            2'b10: calc = a ^ b;
            2'b11: calc = ~(a | b);
            default: calc = '0;
        endcase
    end

    assign calc_zero = (calc == '0);

    assign in_ready  = ~state_reg[0];
    assign out_valid = state_reg[1];
    assign result    = main_result_reg;
    assign zero      = main_zero_reg;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (emit) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists
                if (emit) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_result_reg <= '0;
            main_zero_reg   <= 1'b0;
        end else if (load_main_in) begin
            main_result_reg <= calc;
            main_zero_reg   <= calc_zero;
        end else if (load_main_skid) begin
            main_result_reg <= skid_result_reg;
            main_zero_reg   <= skid_zero_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_result_reg <= '0;
            skid_zero_reg   <= 1'b0;
        end else if (load_skid) begin
            skid_result_reg <= calc;
            skid_zero_reg   <= calc_zero;
        end
    end

endmodule

// File: tb/tb_logic_stage.sv
// Directed bench for logic_stage: reset, all ops, zero flag, skid backpressure,
// full throughput and reset while full.
module tb_logic_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;

    int checks;
    int errors;

    logic_stage #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        logic [7:0] r;
        r = 8'h00;
        if (o == 2'd0) r = x & y;
        if (o == 2'd1) r = x | y;
        if (o == 2'd2) r = x ^ y;
        if (o == 2'd3) r = 8'hFF ^ (x | y);
        return r;
    endfunction

    task automatic test_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h0F; b = 8'hFF; op = 2'b00;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h0F) begin
            errors++;
            $display("FAIL preload: out_valid=%b result=%h required 1/0f", out_valid, result);
        end
        #4 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b result=%h zero=%b in_ready=%b required 0/00/0/1",
                     out_valid, result, zero, in_ready);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle[%0d]: out_valid=%b result=%h zero=%b in_ready=%b required 0/00/0/1",
                         i, out_valid, result, zero, in_ready);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_all_ops();
        logic [7:0] expv [4];
        expv[0] = 8'h30; expv[1] = 8'hFC; expv[2] = 8'hCC; expv[3] = 8'h03;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            op = 2'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || result !== expv[i] || zero !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL all_ops[%0d]: out_valid=%b result=%h zero=%b in_ready=%b required 1/%h/0/1",
                         i, out_valid, result, zero, in_ready, expv[i]);
            end
            $display("all_ops op=%0d result=%h zero=%b", i, result, zero);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_ops_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_zero_flag();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [1:0] vo [3];
        logic [7:0] er [3];
        logic       ez [3];
        va[0] = 8'hAA; vb[0] = 8'h55; vo[0] = 2'b00; er[0] = 8'h00; ez[0] = 1'b1;
        va[1] = 8'hFF; vb[1] = 8'h00; vo[1] = 2'b11; er[1] = 8'h00; ez[1] = 1'b1;
        va[2] = 8'h00; vb[2] = 8'h00; vo[2] = 2'b11; er[2] = 8'hFF; ez[2] = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = va[i]; b = vb[i]; op = vo[i];
            step();
            checks++;
            if (out_valid !== 1'b1 || result !== er[i] || zero !== ez[i]) begin
                errors++;
                $display("FAIL zero_flag[%0d]: out_valid=%b result=%h zero=%b required 1/%h/%b",
                         i, out_valid, result, zero, er[i], ez[i]);
            end
            $display("zero_flag a=%h b=%h op=%0d result=%h zero=%b", va[i], vb[i], vo[i], result, zero);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        b = 8'hFF; op = 2'b00;
        a = 8'h01;
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h01 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: out_valid=%b result=%h in_ready=%b required 1/01/1", out_valid, result, in_ready);
        end
        a = 8'h02;
        step();
        checks++;
        if (in_ready !== 1'b0 || result !== 8'h01) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b result=%h required 0/01", in_ready, result);
        end
        a = 8'h03;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'h01 || zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b result=%h zero=%b required 0/1/01/0",
                         i, in_ready, out_valid, result, zero);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h02 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain1: out_valid=%b result=%h in_ready=%b required 1/02/1", out_valid, result, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h03) begin
            errors++;
            $display("FAIL bp_drain2: out_valid=%b result=%h required 1/03", out_valid, result);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_r;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = 2'($urandom_range(0, 3));
            exp_r = model(a, b, op);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || result !== exp_r || zero !== (exp_r == 8'h00)) begin
                errors++;
                $display("FAIL b2b[%0d]: out_valid=%b result=%h zero=%b required 1/%h/%b",
                         i, out_valid, result, zero, exp_r, (exp_r == 8'h00));
            end
            $display("b2b[%0d] a=%h b=%h op=%0d result=%h", i, a, b, op, result);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h11; b = 8'h22; op = 2'b01;
        step();
        a = 8'h44; b = 8'h88; op = 2'b10;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_full: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
        end
        #4 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h00) begin
            errors++;
            $display("FAIL rm_reset: out_valid=%b in_ready=%b result=%h required 0/1/00", out_valid, in_ready, result);
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'h0F; b = 8'hF0; op = 2'b01;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'hFF || zero !== 1'b0) begin
            errors++;
            $display("FAIL rm_new: out_valid=%b result=%h zero=%b required 1/ff/0", out_valid, result, zero);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rm_ghost[%0d]: out_valid=%b result=%h required out_valid 0", i, out_valid, result);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 8'h00; b = 8'h00; op = 2'b00;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_all_ops();
        test_zero_flag();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
